// File: rtl/wb_scoreboard.sv
// Writeback scoreboard: checks register-file writes in order against a
// preloaded queue of expected (register, value) pairs.
module wb_scoreboard #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int DEPTH     = 32,
    parameter int TIMEOUT   = 64,
    parameter int IGNORE_X0 = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [REG_AW-1:0]            exp_reg,
    input  logic [DATA_W-1:0]            exp_data,
    input  logic                         start,
    input  logic                         clear,
    input  logic                         wb_en,
    input  logic [REG_AW-1:0]            wb_rd,
    input  logic [DATA_W-1:0]            wb_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timed_out,
    output logic                         fail_pulse,
    output logic [$clog2(DEPTH+1)-1:0]   pass_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   fail_cnt,
    output logic [$clog2(DEPTH)-1:0]     first_fail_idx,
    output logic [DATA_W-1:0]            first_fail_got,
    output logic [DATA_W-1:0]            first_fail_exp
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = REG_AW + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [TW-1:0]     tcnt;

    logic              empty;
    logic              full;
    logic              push;
    logic              accept;
    logic              match;
    logic              last;
    logic              tmo_hit;
    logic              start_ok;
    logic              is_x0;
    logic [REG_AW-1:0] head_reg;
    logic [DATA_W-1:0] head_data;

    // Wrap bit distinguishes a full queue from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign exp_ready = (state_q == S_IDLE) && !full;
    assign push      = exp_valid && exp_ready && !clear;

    assign {head_reg, head_data} = mem[rd_ptr[AW-1:0]];

    assign is_x0  = (IGNORE_X0 != 0) && (wb_rd == '0);
    assign accept = (state_q == S_RUN) && wb_en && !is_x0;
    assign match  = (wb_rd == head_reg) && (wb_data == head_data);
    assign last   = ((rd_ptr + (AW+1)'(1)) == wr_ptr);

    // An accepted writeback in the expiry cycle keeps the run alive.
    assign tmo_hit = (state_q == S_RUN) && !accept &&
                     (tcnt == TW'(TIMEOUT-1));

    // An entry pushed alongside start is part of the run.
    assign start_ok = (state_q == S_IDLE) && start && (!empty || push);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if ((accept && last) || tmo_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clear) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {exp_reg, exp_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            tcnt           <= '0;
            timed_out      <= 1'b0;
            fail_pulse     <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            first_fail_exp <= '0;
        end else if (clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            tcnt           <= '0;
            timed_out      <= 1'b0;
            fail_pulse     <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            first_fail_exp <= '0;
        end else begin
            fail_pulse <= accept && !match;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (accept) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (start_ok || accept) begin
                tcnt <= '0;
            end else if (state_q == S_RUN) begin
                tcnt <= tcnt + TW'(1);
            end
            if (tmo_hit) begin
                timed_out <= 1'b1;
            end
            if (accept && match) begin
                pass_cnt <= pass_cnt + CW'(1);
            end
            if (accept && !match) begin
                fail_cnt <= fail_cnt + CW'(1);
                if (fail_cnt == '0) begin
                    first_fail_idx <= rd_ptr[AW-1:0];
                    first_fail_got <= wb_data;
                    first_fail_exp <= head_data;
                end
            end
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign pass = done && (fail_cnt == '0) && !timed_out;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed plus randomized bench for wb_scoreboard against a
// queue-based reference model.
module tb_wb_scoreboard;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CW      = $clog2(DEPTH+1);
    localparam int AW      = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              exp_valid = 1'b0;
    logic              exp_ready;
    logic [REG_AW-1:0] exp_reg = '0;
    logic [DATA_W-1:0] exp_data = '0;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic              wb_en = 1'b0;
    logic [REG_AW-1:0] wb_rd = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timed_out;
    logic              fail_pulse;
    logic [CW-1:0]     pass_cnt;
    logic [CW-1:0]     fail_cnt;
    logic [AW-1:0]     first_fail_idx;
    logic [DATA_W-1:0] first_fail_got;
    logic [DATA_W-1:0] first_fail_exp;

    wb_scoreboard #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
        .TIMEOUT(TIMEOUT), .IGNORE_X0(1)
    ) dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_reg(exp_reg), .exp_data(exp_data),
        .start(start), .clear(clear),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .done(done), .pass(pass),
        .timed_out(timed_out), .fail_pulse(fail_pulse),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx),
        .first_fail_got(first_fail_got),
        .first_fail_exp(first_fail_exp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [REG_AW-1:0] r;
        logic [DATA_W-1:0] d;
        logic [AW-1:0]     idx;
    } ent_t;

    ent_t        mq[$];
    int          m_load;
    bit          m_busy, m_done, m_to;
    int          m_pass, m_fail;
    logic [AW-1:0]     m_ff_idx;
    logic [DATA_W-1:0] m_ff_got, m_ff_exp;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        mq.delete();
        m_load = 0;
        m_busy = 0; m_done = 0; m_to = 0;
        m_pass = 0; m_fail = 0;
        m_ff_idx = '0; m_ff_got = '0; m_ff_exp = '0;
    endtask

    task automatic check_all(input string tag);
        bit rdy = !m_busy && !m_done && (mq.size() < DEPTH);
        chk({tag, ".busy"}, busy, m_busy);
        chk({tag, ".done"}, done, m_done);
        chk({tag, ".pass"}, pass, m_done && m_fail == 0 && !m_to);
        chk({tag, ".timed_out"}, timed_out, m_to);
        chk({tag, ".exp_ready"}, exp_ready, rdy);
        chk({tag, ".pass_cnt"}, pass_cnt, m_pass);
        chk({tag, ".fail_cnt"}, fail_cnt, m_fail);
        chk({tag, ".ff_idx"}, first_fail_idx, m_ff_idx);
        chk({tag, ".ff_got"}, first_fail_got, m_ff_got);
        chk({tag, ".ff_exp"}, first_fail_exp, m_ff_exp);
    endtask

    task automatic load(input logic [REG_AW-1:0] r,
                        input logic [DATA_W-1:0] d);
        bit rdy = !m_busy && !m_done && (mq.size() < DEPTH);
        exp_valid = 1'b1; exp_reg = r; exp_data = d;
        chk("load.exp_ready", exp_ready, rdy);
        cyc();
        exp_valid = 1'b0;
        if (rdy) begin
            mq.push_back('{r: r, d: d, idx: AW'(m_load)});
            m_load++;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (!m_busy && !m_done && mq.size() > 0) m_busy = 1;
        check_all("start");
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        m_reset();
        check_all("clear");
    endtask

    task automatic do_wb(input logic [REG_AW-1:0] rd,
                         input logic [DATA_W-1:0] d);
        bit   mism = 0;
        ent_t e;
        wb_en = 1'b1; wb_rd = rd; wb_data = d;
        cyc();
        wb_en = 1'b0;
        if (m_busy && rd != 0) begin
            e = mq.pop_front();
            if (rd == e.r && d == e.d) begin
                m_pass++;
            end else begin
                mism = 1;
                if (m_fail == 0) begin
                    m_ff_idx = e.idx; m_ff_got = d; m_ff_exp = e.d;
                end
                m_fail++;
            end
            if (mq.size() == 0) begin
                m_busy = 0; m_done = 1;
            end
        end
        chk("wb.fail_pulse", fail_pulse, mism);
        check_all("wb");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("idle.fail_pulse", fail_pulse, 1'b0);
        end
    endtask

    initial begin
        int n;
        m_reset();
        repeat (2) cyc();
        rst = 1'b0;
        check_all("reset");

        // In-order all-match run with gaps.
        load(1, 100); load(2, 100); load(30, 12); load(1, 200);
        do_start();
        do_wb(1, 100);  idle(1);
        do_wb(2, 100);  idle(1);
        do_wb(30, 12);  idle(1);
        do_wb(1, 200);  idle(1);
        check_all("allmatch");

        // Single data mismatch on the second entry.
        do_clear();
        load(1, 150); load(11, 32'hEF);
        do_start();
        do_wb(1, 150);
        do_wb(11, 32'hEE);
        idle(1);
        check_all("mismatch");

        // Writes to x0 are skipped.
        do_clear();
        load(5, 32'hEF);
        do_start();
        do_wb(0, 32'h1234);
        do_wb(5, 32'hEF);
        idle(1);
        check_all("x0");

        // Stall after one acceptance expires after TIMEOUT cycles.
        do_clear();
        load(3, 7); load(4, 8);
        do_start();
        do_wb(3, 7);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (done) begin
                n = i;
                break;
            end
        end
        chk("timeout_latency", n, TIMEOUT);
        m_busy = 0; m_done = 1; m_to = 1;
        check_all("timeout");

        // Queue fills at DEPTH; the extra offer is refused.
        do_clear();
        for (int i = 0; i < DEPTH + 1; i++) load(REG_AW'(i + 1), 32'(i * 3));
        do_start();
        for (int i = 0; i < DEPTH; i++) do_wb(REG_AW'(i + 1), 32'(i * 3));
        do_clear();

        // start together with the first push counts that entry.
        exp_valid = 1'b1; exp_reg = 9; exp_data = 32'h55;
        start = 1'b1;
        cyc();
        exp_valid = 1'b0; start = 1'b0;
        mq.push_back('{r: 9, d: 32'h55, idx: '0});
        m_load = 1; m_busy = 1;
        check_all("start_push");
        do_wb(9, 32'h55);
        do_clear();

        // clear beats start.
        load(6, 1);
        clear = 1'b1; start = 1'b1;
        cyc();
        clear = 1'b0; start = 1'b0;
        m_reset();
        check_all("clear_prio");

        // Async reset mid-run drops everything.
        load(1, 10); load(2, 20); load(3, 30);
        do_start();
        do_wb(1, 10);
        do_wb(2, 20);
        rst = 1'b1;
        #1;
        m_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_start();

        // Randomized runs.
        for (int round = 0; round < 25; round++) begin
            int   k;
            ent_t tmp[$];
            do_clear();
            k = $urandom_range(1, DEPTH);
            for (int i = 0; i < k; i++) begin
                logic [REG_AW-1:0] r = REG_AW'($urandom_range(1, 31));
                logic [DATA_W-1:0] d = $urandom;
                load(r, d);
                tmp.push_back('{r: r, d: d, idx: AW'(i)});
            end
            do_start();
            foreach (tmp[i]) begin
                logic [REG_AW-1:0] r = tmp[i].r;
                logic [DATA_W-1:0] d = tmp[i].d;
                if ($urandom_range(0, 3) == 0) do_wb(0, $urandom);
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        d = d ^ (32'd1 << $urandom_range(0, 31));
                    else
                        r = (r == 31) ? 5'd30 : r + 5'd1;
                end
                do_wb(r, d);
                idle($urandom_range(0, 2));
            end
            idle(1);
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
